// File: rtl/data_mem_arbiter.sv
// Two-port arbiter in front of the data-memory BRAM, with a one-word-per-cycle zero-fill sequencer.
// Define ARB_ROUND_ROBIN_EN for round-robin contention handling; fixed priority (port 0) otherwise.
module data_mem_arbiter #(
    parameter int MEM_SIZE = 1024,
    parameter int IDX_W    = $clog2(MEM_SIZE)
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic        req0_we,
    input  logic [31:0] req0_addr,
    input  logic [31:0] req0_wdata,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic        req1_we,
    input  logic [31:0] req1_addr,
    input  logic [31:0] req1_wdata,
    output logic        rsp0_valid,
    output logic [31:0] rsp0_rdata,
    output logic        rsp1_valid,
    output logic [31:0] rsp1_rdata,
    input  logic        clear_start,
    output logic        clear_busy,
    output logic        clear_done,
    output logic [31:0] mem_read_addr,
    input  logic [31:0] mem_read_data,
    output logic [31:0] mem_write_addr,
    output logic [31:0] mem_write_data,
    output logic        mem_write_enable
);

    // state  | meaning
    // IDLE   | arbitrate requests, one grant per cycle
    // CLEAR  | zero-fill memory, requests held off
    typedef enum logic {S_IDLE, S_CLEAR} state_t;

    state_t           state_q, state_d;
    logic [IDX_W-1:0] cnt_q, cnt_d;
    logic             rsp_pend_q, rsp_pend_d;
    logic             rsp_port_q, rsp_port_d;
    logic             rsp_oob_q, rsp_oob_d;
    logic             done_q, done_d;

    logic             gnt_port;
    logic             sel_we;
    logic [31:0]      sel_addr;
    logic [31:0]      sel_wdata;
    logic             sel_oob;

`ifdef ARB_ROUND_ROBIN_EN
    logic             last_q, last_d;
`endif

    always_comb begin
        gnt_port = 1'b0;
        if (req0_valid && req1_valid) begin
`ifdef ARB_ROUND_ROBIN_EN
            gnt_port = ~last_q;
`else
            gnt_port = 1'b0;
`endif
        end else begin
            gnt_port = req1_valid;
        end
        sel_we    = gnt_port ? req1_we    : req0_we;
        sel_addr  = gnt_port ? req1_addr  : req0_addr;
        sel_wdata = gnt_port ? req1_wdata : req0_wdata;
        sel_oob   = (sel_addr >= 32'(MEM_SIZE));
    end

    always_comb begin
        state_d          = state_q;
        cnt_d            = cnt_q;
        rsp_pend_d       = 1'b0;
        rsp_port_d       = rsp_port_q;
        rsp_oob_d        = rsp_oob_q;
        done_d           = 1'b0;
        req0_ready       = 1'b0;
        req1_ready       = 1'b0;
        clear_busy       = 1'b0;
        mem_read_addr    = 32'h0;
        mem_write_addr   = 32'h0;
        mem_write_data   = 32'h0;
        mem_write_enable = 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
        last_d           = last_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (clear_start) begin
                    state_d = S_CLEAR;
                    cnt_d   = '0;
                end else if (rst && (req0_valid || req1_valid)) begin
                    req0_ready = ~gnt_port;
                    req1_ready = gnt_port;
`ifdef ARB_ROUND_ROBIN_EN
                    last_d     = gnt_port;
`endif
                    if (sel_we) begin
                        // Out-of-range writes are accepted but never reach the BRAM.
                        mem_write_enable = ~sel_oob;
                        mem_write_addr   = sel_addr;
                        mem_write_data   = sel_wdata;
                    end else begin
                        mem_read_addr = sel_addr;
                        rsp_pend_d    = 1'b1;
                        rsp_port_d    = gnt_port;
                        rsp_oob_d     = sel_oob;
                    end
                end
            end
            S_CLEAR: begin
                clear_busy       = 1'b1;
                mem_write_enable = 1'b1;
                mem_write_addr   = 32'(cnt_q);
                if (cnt_q == IDX_W'(MEM_SIZE - 1)) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + IDX_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        rsp0_valid = rsp_pend_q & ~rsp_port_q;
        rsp1_valid = rsp_pend_q & rsp_port_q;
        rsp0_rdata = (rsp0_valid && !rsp_oob_q) ? mem_read_data : 32'h0;
        rsp1_rdata = (rsp1_valid && !rsp_oob_q) ? mem_read_data : 32'h0;
        clear_done = done_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            rsp_pend_q <= 1'b0;
            rsp_port_q <= 1'b0;
            rsp_oob_q  <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rsp_pend_q <= rsp_pend_d;
            rsp_port_q <= rsp_port_d;
            rsp_oob_q  <= rsp_oob_d;
            done_q     <= done_d;
        end
    end

`ifdef ARB_ROUND_ROBIN_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) last_q <= 1'b1;
        else      last_q <= last_d;
    end
`endif

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Directed bench: dut_a uses the default 1024-word memory, dut_b a 16-word memory for clear tests.
module tb_data_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst_a, rst_b, clr_a, clr_b;
    logic        r0v, r0we, r1v, r1we;
    logic [31:0] r0addr, r0wd, r1addr, r1wd;

    logic        a_rdy0, a_rdy1, a_rv0, a_rv1, a_busy, a_done, a_we;
    logic [31:0] a_rd0, a_rd1, a_raddr, a_waddr, a_wdata;
    logic [31:0] a_mrd = 32'h0;
    logic        b_rdy0, b_rdy1, b_rv0, b_rv1, b_busy, b_done, b_we;
    logic [31:0] b_rd0, b_rd1, b_raddr, b_waddr, b_wdata;
    logic [31:0] b_mrd = 32'h0;

    logic [31:0] mem_a [1024];
    logic [31:0] mem_b [16];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    data_mem_arbiter dut_a (
        .clk(clk), .rst(rst_a),
        .req0_valid(r0v), .req0_ready(a_rdy0), .req0_we(r0we), .req0_addr(r0addr), .req0_wdata(r0wd),
        .req1_valid(r1v), .req1_ready(a_rdy1), .req1_we(r1we), .req1_addr(r1addr), .req1_wdata(r1wd),
        .rsp0_valid(a_rv0), .rsp0_rdata(a_rd0), .rsp1_valid(a_rv1), .rsp1_rdata(a_rd1),
        .clear_start(clr_a), .clear_busy(a_busy), .clear_done(a_done),
        .mem_read_addr(a_raddr), .mem_read_data(a_mrd), .mem_write_addr(a_waddr),
        .mem_write_data(a_wdata), .mem_write_enable(a_we)
    );

    data_mem_arbiter #(.MEM_SIZE(16), .IDX_W(4)) dut_b (
        .clk(clk), .rst(rst_b),
        .req0_valid(r0v), .req0_ready(b_rdy0), .req0_we(r0we), .req0_addr(r0addr), .req0_wdata(r0wd),
        .req1_valid(r1v), .req1_ready(b_rdy1), .req1_we(r1we), .req1_addr(r1addr), .req1_wdata(r1wd),
        .rsp0_valid(b_rv0), .rsp0_rdata(b_rd0), .rsp1_valid(b_rv1), .rsp1_rdata(b_rd1),
        .clear_start(clr_b), .clear_busy(b_busy), .clear_done(b_done),
        .mem_read_addr(b_raddr), .mem_read_data(b_mrd), .mem_write_addr(b_waddr),
        .mem_write_data(b_wdata), .mem_write_enable(b_we)
    );

    // BRAM models: read-before-write, out-of-range reads return a marker the DUT must suppress
    always @(posedge clk) begin
        if (a_we && a_waddr < 32'd1024) mem_a[a_waddr[9:0]] <= a_wdata;
        a_mrd <= (a_raddr < 32'd1024) ? mem_a[a_raddr[9:0]] : 32'hBAD0BAD0;
        if (b_we && b_waddr < 32'd16) mem_b[b_waddr[3:0]] <= b_wdata;
        b_mrd <= (b_raddr < 32'd16) ? mem_b[b_raddr[3:0]] : 32'hBAD0BAD0;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [3:0] exp_gnt;
        logic       done_seen;
        for (int i = 0; i < 1024; i++) mem_a[i] = 32'h0;
        for (int i = 0; i < 16; i++) mem_b[i] = 32'h0;
        rst_a = 1'b0; rst_b = 1'b0; clr_a = 1'b0; clr_b = 1'b0;
        r0v = 1'b0; r0we = 1'b0; r0addr = '0; r0wd = '0;
        r1v = 1'b0; r1we = 1'b0; r1addr = '0; r1wd = '0;

        // T1: reset with random inputs
        for (int i = 0; i < 4; i++) begin
            step();
            r0v = 1'($urandom); r0we = 1'($urandom); r0addr = 32'($urandom_range(0, 2047)); r0wd = $urandom;
            r1v = 1'($urandom); r1we = 1'($urandom); r1addr = 32'($urandom_range(0, 2047)); r1wd = $urandom;
            clr_a = 1'($urandom); clr_b = 1'($urandom);
            #1;
            chk("rst_outs_a", 32'(|{a_rdy0, a_rdy1, a_rv0, a_rv1, a_rd0, a_rd1, a_busy, a_done,
                                   a_raddr, a_waddr, a_wdata, a_we}), 32'h0);
            chk("rst_outs_b", 32'(|{b_rdy0, b_rdy1, b_rv0, b_rv1, b_rd0, b_rd1, b_busy, b_done,
                                   b_raddr, b_waddr, b_wdata, b_we}), 32'h0);
        end
        step();
        r0v = 1'b0; r0we = 1'b0; r0addr = '0; r0wd = '0;
        r1v = 1'b0; r1we = 1'b0; r1addr = '0; r1wd = '0;
        clr_a = 1'b0; clr_b = 1'b0;
        rst_a = 1'b1; rst_b = 1'b1;
        #1;
        chk("idle_we", 32'(a_we), 32'h0);
        chk("idle_raddr", a_raddr, 32'h0);
        step(); r0v = 1'b1; #1;
        chk("t1_rdy0", 32'(a_rdy0), 32'h1);
        chk("t1_rdy1", 32'(a_rdy1), 32'h0);
        step(); r0v = 1'b0; #1;
        chk("t1_rv0", 32'(a_rv0), 32'h1);
        chk("t1_rd0", a_rd0, 32'h0);
        chk("t1_rv1", 32'(a_rv1), 32'h0);

        // T2: port-0 write then port-1 read of the same word
        step(); r0v = 1'b1; r0we = 1'b1; r0addr = 32'h10; r0wd = 32'hDEADBEEF; #1;
        chk("t2_wr_rdy0", 32'(a_rdy0), 32'h1);
        chk("t2_wr_we", 32'(a_we), 32'h1);
        chk("t2_wr_addr", a_waddr, 32'h10);
        chk("t2_wr_data", a_wdata, 32'hDEADBEEF);
        step(); r0v = 1'b0; r0we = 1'b0; r1v = 1'b1; r1we = 1'b0; r1addr = 32'h10; #1;
        chk("t2_rd_rdy1", 32'(a_rdy1), 32'h1);
        chk("t2_rd_addr", a_raddr, 32'h10);
        chk("t2_rd_we", 32'(a_we), 32'h0);
        step(); r1v = 1'b0; #1;
        chk("t2_rv1", 32'(a_rv1), 32'h1);
        chk("t2_rd1", a_rd1, 32'hDEADBEEF);
        chk("t2_rv0", 32'(a_rv0), 32'h0);
        step(); #1;
        chk("t2_rv1_pulse", 32'(a_rv1), 32'h0);

        // T3: contention for four cycles, both reading 0x10
`ifdef ARB_ROUND_ROBIN_EN
        exp_gnt = 4'b1010;
`else
        exp_gnt = 4'b0000;
`endif
        for (int i = 0; i < 4; i++) begin
            step();
            r0v = 1'b1; r0addr = 32'h10; r1v = 1'b1; r1addr = 32'h10;
            #1;
            chk($sformatf("t3_rdy0_%0d", i), 32'(a_rdy0), 32'(!exp_gnt[i]));
            chk($sformatf("t3_rdy1_%0d", i), 32'(a_rdy1), 32'(exp_gnt[i]));
            if (i > 0) chk($sformatf("t3_rv1_%0d", i), 32'(a_rv1), 32'(exp_gnt[i-1]));
        end
        step(); r0v = 1'b0; r1v = 1'b0; #1;
        chk("t3_last_rv1", 32'(a_rv1), 32'(exp_gnt[3]));
        chk("t3_last_rd0", a_rd0, exp_gnt[3] ? 32'h0 : 32'hDEADBEEF);

        // T6: out-of-range accesses on the 1024-word instance
        step(); r1v = 1'b1; r1we = 1'b1; r1addr = 32'd1024; r1wd = 32'h55; #1;
        chk("t6_wr_rdy1", 32'(a_rdy1), 32'h1);
        chk("t6_wr_we", 32'(a_we), 32'h0);
        step(); r1we = 1'b0; #1;
        chk("t6_rd_rdy1", 32'(a_rdy1), 32'h1);
        chk("t6_rd_addr", a_raddr, 32'd1024);
        step(); r1v = 1'b0; #1;
        chk("t6_rv1", 32'(a_rv1), 32'h1);
        chk("t6_rd1", a_rd1, 32'h0);

        // T4: clear on the 16-word instance, with a read in flight when clear_start arrives
        step(); r0v = 1'b1; r0we = 1'b1; r0addr = 32'd15; r0wd = 32'h12345678; #1;
        chk("t4_pre_we", 32'(b_we), 32'h1);
        step(); r0v = 1'b0; r0we = 1'b0; r1v = 1'b1; r1we = 1'b0; r1addr = 32'd15; #1;
        chk("t4_pre_rdy1", 32'(b_rdy1), 32'h1);
        step(); r1v = 1'b0; clr_b = 1'b1; r0v = 1'b1; r0we = 1'b0; r0addr = 32'd15; #1;
        chk("t4_inflight_rv1", 32'(b_rv1), 32'h1);
        chk("t4_inflight_rd1", b_rd1, 32'h12345678);
        chk("t4_start_rdy0", 32'(b_rdy0), 32'h0);
        chk("t4_start_we", 32'(b_we), 32'h0);
        for (int k = 1; k <= 16; k++) begin
            step(); clr_b = (k == 3); #1;
            chk($sformatf("t4_we_%0d", k), 32'(b_we), 32'h1);
            chk($sformatf("t4_addr_%0d", k), b_waddr, 32'(k - 1));
            chk($sformatf("t4_data_%0d", k), b_wdata, 32'h0);
            chk($sformatf("t4_rdy0_%0d", k), 32'(b_rdy0), 32'h0);
            chk($sformatf("t4_busy_%0d", k), 32'(b_busy), 32'h1);
            chk($sformatf("t4_done_%0d", k), 32'(b_done), 32'h0);
        end
        step(); clr_b = 1'b0; #1;
        chk("t4_done17", 32'(b_done), 32'h1);
        chk("t4_busy17", 32'(b_busy), 32'h0);
        chk("t4_rdy0_17", 32'(b_rdy0), 32'h1);
        step(); r0v = 1'b0; #1;
        chk("t4_rv0", 32'(b_rv0), 32'h1);
        chk("t4_rd0", b_rd0, 32'h0);
        chk("t4_done_pulse", 32'(b_done), 32'h0);

        // T5: reset while the clear is writing address 5
        step(); clr_b = 1'b1; #1;
        for (int k = 1; k <= 6; k++) begin
            step(); clr_b = 1'b0; #1;
        end
        chk("t5_addr5", b_waddr, 32'd5);
        chk("t5_we5", 32'(b_we), 32'h1);
        rst_b = 1'b0; #1;
        chk("t5_rst_outs", 32'(|{b_rdy0, b_rdy1, b_rv0, b_rv1, b_rd0, b_rd1, b_busy, b_done,
                                  b_raddr, b_waddr, b_wdata, b_we}), 32'h0);
        step(); step(); rst_b = 1'b1;
        done_seen = 1'b0;
        for (int k = 0; k < 20; k++) begin
            step();
            if (b_done || b_busy) done_seen = 1'b1;
        end
        chk("t5_no_done", 32'(done_seen), 32'h0);
        r0v = 1'b1; r0we = 1'b0; r0addr = 32'd2; #1;
        chk("t5_rdy0", 32'(b_rdy0), 32'h1);
        step(); r0v = 1'b0; #1;
        chk("t5_rv0", 32'(b_rv0), 32'h1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
